fp_mant_addsub_pipe: RTL and testbench

//  Parametrised, pipelined successor to the single-precision mantissa add/sub stage of the FP adder.
//  - Takes two exponent-aligned extended mantissas and their signs, plus an add/sub op and rounding mode.
//  - Produces a signed-magnitude sum, a carry-out, compressed guard/round/sticky bits, a leading-zero

---
 rtl/fp_mant_addsub_pipe_if.sv | 50 +++++
 rtl/fp_mant_addsub_pipe.sv | 165 ++++++++++++++++
 tb/tb_fp_mant_addsub_pipe.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/fp_mant_addsub_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : fp_mant_addsub_pipe_if
// Purpose  : Handshake and data bundle between the align stage, the mantissa
//            add/sub pipeline and the normalise/round stage.
// Revision : 1.0 - initial release
// ============================================================================
interface fp_mant_addsub_pipe_if #(
  parameter int MANT_W = 24,
  parameter int EXT_W  = 24
);
  localparam int LZC_W = $clog2(MANT_W + 1);

  // Upstream side
  logic                      in_valid;
  logic                      in_ready;
  logic                      op_sub;
  logic [2:0]                rm;
  logic                      sign_a;
  logic                      sign_b;
  logic [MANT_W+EXT_W-1:0]   mant_a;
  logic [MANT_W+EXT_W-1:0]   mant_b;

  // Downstream side
  logic                      out_valid;
  logic                      out_ready;
  logic [MANT_W-1:0]         mant_sum;
  logic                      carry;
  logic                      guard;
  logic                      round_b;
  logic                      sticky;
  logic [LZC_W-1:0]          lzc;
  logic                      sign_res;
  logic                      zero_res;

  // Surrounding FPU logic: drives operands and downstream ready
  modport master (
    output in_valid, op_sub, rm, sign_a, sign_b, mant_a, mant_b, out_ready,
    input  in_ready, out_valid, mant_sum, carry, guard, round_b, sticky,
           lzc, sign_res, zero_res
  );

  // The add/sub pipeline itself
  modport slave (
    input  in_valid, op_sub, rm, sign_a, sign_b, mant_a, mant_b, out_ready,
    output in_ready, out_valid, mant_sum, carry, guard, round_b, sticky,
           lzc, sign_res, zero_res
  );
endinterface
`default_nettype wire

// File: rtl/fp_mant_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fp_mant_addsub_pipe
// Purpose  : Two-stage pipelined signed-magnitude add/sub of exponent-aligned
//            extended mantissas. Stage 1 forms the magnitude and sign, stage 2
//            splits it into mantissa / G / R / S and counts leading zeros.
//            EXT_W must be at least 3 so guard, round and sticky all exist.
// Revision : 1.0 - initial release
// ============================================================================
module fp_mant_addsub_pipe #(
  parameter int MANT_W = 24,
  parameter int EXT_W  = 24
) (
  input  wire logic             clk,
  input  wire logic             rst,
  fp_mant_addsub_pipe_if.slave  bus_if
);

  localparam int          LZC_W    = $clog2(MANT_W + 1);
  localparam int          C_FULL_W = MANT_W + EXT_W;
  localparam logic [2:0]  C_RM_RDN = 3'b010;

  // Handshake
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic s1_load;
  logic s2_load;
  logic s2_take;
  logic in_ready_w;

  // Stage 1 datapath
  logic                eff_sb;
  logic                same_sign;
  logic                a_gt_b;
  logic                a_eq_b;
  logic [C_FULL_W:0]   s1_sum_d,  s1_sum_q;
  logic                s1_sign_d, s1_sign_q;

  // Stage 2 datapath
  logic [MANT_W-1:0]   s2_mant_d,   s2_mant_q;
  logic [EXT_W-1:0]    s2_ext;
  logic                s2_carry_d,  s2_carry_q;
  logic                s2_guard_d,  s2_guard_q;
  logic                s2_round_d,  s2_round_q;
  logic                s2_sticky_d, s2_sticky_q;
  logic [LZC_W-1:0]    s2_lzc_d,    s2_lzc_q;
  logic                s2_sign_d,   s2_sign_q;
  logic                s2_zero_d,   s2_zero_q;

  // A stage loads when it is empty or its occupant leaves this cycle
  assign s2_load    = ~s2_valid_q | bus_if.out_ready;
  assign in_ready_w = ~s1_valid_q | s2_load;
  assign s1_load    = bus_if.in_valid & in_ready_w;
  assign s2_take    = s2_load & s1_valid_q;

  // Stage-valid next state; stage 2 drains to a bubble when stage 1 is empty
  always_comb begin
    s1_valid_d = in_ready_w ? bus_if.in_valid : s1_valid_q;
    s2_valid_d = s2_load    ? s1_valid_q      : s2_valid_q;
  end

  // Stage 1: effective operation, magnitude and sign of the result
  always_comb begin
    eff_sb    = bus_if.sign_b ^ bus_if.op_sub;
    same_sign = (bus_if.sign_a == eff_sb);
    a_gt_b    = (bus_if.mant_a > bus_if.mant_b);
    a_eq_b    = (bus_if.mant_a == bus_if.mant_b);
    s1_sum_d  = '0;
    s1_sign_d = bus_if.sign_a;
    if (same_sign) begin
      s1_sum_d  = {1'b0, bus_if.mant_a} + {1'b0, bus_if.mant_b};
      s1_sign_d = bus_if.sign_a;
    end else if (a_gt_b) begin
      s1_sum_d  = {1'b0, bus_if.mant_a - bus_if.mant_b};
      s1_sign_d = bus_if.sign_a;
    end else if (a_eq_b) begin
      // Exact cancellation: -0 only when rounding toward negative infinity
      s1_sum_d  = '0;
      s1_sign_d = (bus_if.rm == C_RM_RDN);
    end else begin
      s1_sum_d  = {1'b0, bus_if.mant_b - bus_if.mant_a};
      s1_sign_d = eff_sb;
    end
  end

  // Stage 2: split the sum, compress the extension, flag exact zero
  always_comb begin
    s2_carry_d  = s1_sum_q[C_FULL_W];
    s2_mant_d   = s1_sum_q[C_FULL_W-1:EXT_W];
    s2_ext      = s1_sum_q[EXT_W-1:0];
    s2_guard_d  = s2_ext[EXT_W-1];
    s2_round_d  = s2_ext[EXT_W-2];
    s2_sticky_d = |s2_ext[EXT_W-3:0];
    s2_sign_d   = s1_sign_q;
    s2_zero_d   = ~|s1_sum_q;
  end

  // Stage 2: leading-zero priority encoder; the highest set bit wins last
  always_comb begin
    s2_lzc_d = LZC_W'(MANT_W);
    for (int i = 0; i < MANT_W; i++) begin
      if (s2_mant_d[i]) begin
        s2_lzc_d = LZC_W'(MANT_W - 1 - i);
      end
    end
    if (s2_carry_d) begin
      s2_lzc_d = '0;
    end
  end

  // Stage 1 register: captures operands' result on an input transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_sum_q   <= '0;
      s1_sign_q  <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (s1_load) begin
        s1_sum_q  <= s1_sum_d;
        s1_sign_q <= s1_sign_d;
      end
    end
  end

  // Stage 2 register: output register, holds steady through a stall
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q  <= 1'b0;
      s2_mant_q   <= '0;
      s2_carry_q  <= 1'b0;
      s2_guard_q  <= 1'b0;
      s2_round_q  <= 1'b0;
      s2_sticky_q <= 1'b0;
      s2_lzc_q    <= '0;
      s2_sign_q   <= 1'b0;
      s2_zero_q   <= 1'b0;
    end else begin
      s2_valid_q <= s2_valid_d;
      if (s2_take) begin
        s2_mant_q   <= s2_mant_d;
        s2_carry_q  <= s2_carry_d;
        s2_guard_q  <= s2_guard_d;
        s2_round_q  <= s2_round_d;
        s2_sticky_q <= s2_sticky_d;
        s2_lzc_q    <= s2_lzc_d;
        s2_sign_q   <= s2_sign_d;
        s2_zero_q   <= s2_zero_d;
      end
    end
  end

  assign bus_if.in_ready  = in_ready_w;
  assign bus_if.out_valid = s2_valid_q;
  assign bus_if.mant_sum  = s2_mant_q;
  assign bus_if.carry     = s2_carry_q;
  assign bus_if.guard     = s2_guard_q;
  assign bus_if.round_b   = s2_round_q;
  assign bus_if.sticky    = s2_sticky_q;
  assign bus_if.lzc       = s2_lzc_q;
  assign bus_if.sign_res  = s2_sign_q;
  assign bus_if.zero_res  = s2_zero_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_mant_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_mant_addsub_pipe
// Purpose  : Self-checking bench for fp_mant_addsub_pipe (MANT_W=24, EXT_W=24)
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_mant_addsub_pipe;

  localparam int MANT_W = 24;
  localparam int EXT_W  = 24;

  typedef struct {
    logic        carry;
    logic [23:0] mant;
    logic        guard;
    logic        rnd;
    logic        sticky;
    logic [4:0]  lzc;
    logic        sign;
    logic        zero;
  } exp_t;

  typedef struct {
    exp_t e;
    int   acc;
  } item_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  item_t q[$];
  logic        stall_prev = 1'b0;
  logic [35:0] snap = '0;

  fp_mant_addsub_pipe_if #(.MANT_W(MANT_W), .EXT_W(EXT_W)) bif ();

  fp_mant_addsub_pipe #(.MANT_W(MANT_W), .EXT_W(EXT_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain signed-magnitude arithmetic on 64-bit integers
  function automatic exp_t model(input bit sa, input bit sb, input bit sub,
                                 input bit [2:0] r, input logic [47:0] a,
                                 input logic [47:0] b);
    exp_t e;
    longint unsigned s, m;
    bit es, eff;
    int len;
    eff = sb ^ sub;
    if (sa == eff)  begin s = 64'(a) + 64'(b); es = sa;  end
    else if (a > b) begin s = 64'(a) - 64'(b); es = sa;  end
    else if (b > a) begin s = 64'(b) - 64'(a); es = eff; end
    else            begin s = 0;               es = (r == 3'd2); end
    e.carry  = ((s >> 48) & 1) != 0;
    m        = (s >> 24) & 64'hFF_FFFF;
    e.mant   = 24'(m);
    e.guard  = ((s >> 23) & 1) != 0;
    e.rnd    = ((s >> 22) & 1) != 0;
    e.sticky = (s & 64'h3F_FFFF) != 0;
    len = 0;
    while (m != 0) begin m = m >> 1; len++; end
    e.lzc    = e.carry ? 5'd0 : 5'(24 - len);
    e.sign   = es;
    e.zero   = (s == 0);
    return e;
  endfunction

  // Compare process: in-order scoreboard, checked on every live cycle
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      stall_prev = 1'b0;
    end else begin
      chk("in_ready", 64'(bif.in_ready), 64'(!(q.size() == 2 && !bif.out_ready)));
      chk("out_valid", 64'(bif.out_valid), 64'(q.size() > 0 && cyc >= q[0].acc + 1));
      if (bif.out_valid) begin
        if (stall_prev)
          chk("stall_hold", 64'({bif.mant_sum, bif.carry, bif.guard, bif.round_b,
                                 bif.sticky, bif.lzc, bif.sign_res, bif.zero_res}), 64'(snap));
        if (q.size() > 0) begin
          chk("carry",    64'(bif.carry),    64'(q[0].e.carry));
          chk("mant_sum", 64'(bif.mant_sum), 64'(q[0].e.mant));
          chk("guard",    64'(bif.guard),    64'(q[0].e.guard));
          chk("round_b",  64'(bif.round_b),  64'(q[0].e.rnd));
          chk("sticky",   64'(bif.sticky),   64'(q[0].e.sticky));
          chk("lzc",      64'(bif.lzc),      64'(q[0].e.lzc));
          chk("sign_res", 64'(bif.sign_res), 64'(q[0].e.sign));
          chk("zero_res", 64'(bif.zero_res), 64'(q[0].e.zero));
          if (bif.out_ready) void'(q.pop_front());
        end
      end
      stall_prev = bif.out_valid & ~bif.out_ready;
      snap = {bif.mant_sum, bif.carry, bif.guard, bif.round_b, bif.sticky,
              bif.lzc, bif.sign_res, bif.zero_res};
      if (bif.in_valid && bif.in_ready)
        q.push_back('{e: model(bif.sign_a, bif.sign_b, bif.op_sub, bif.rm,
                               bif.mant_a, bif.mant_b), acc: cyc + 1});
    end
  end

  task automatic send(input bit sa, input bit sb, input bit sub, input bit [2:0] r,
                      input logic [47:0] a, input logic [47:0] b);
    bit ok = 1'b0;
    bif.sign_a = sa; bif.sign_b = sb; bif.op_sub = sub; bif.rm = r;
    bif.mant_a = a;  bif.mant_b = b;  bif.in_valid = 1'b1;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = bif.in_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) chk("send_timeout", 64'd0, 64'd1);
    bif.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
    if (q.size() != 0) chk("drain_timeout", 64'(q.size()), 64'd0);
  endtask

  exp_t pe;

  initial begin
    bif.in_valid = 1'b0; bif.out_ready = 1'b1; bif.op_sub = 1'b0; bif.rm = 3'd0;
    bif.sign_a = 1'b0; bif.sign_b = 1'b0; bif.mant_a = '0; bif.mant_b = '0;

    // Hand-computed literals pinning the model
    pe = model(0, 0, 0, 3'd0, 48'h800000_000000, 48'h800000_000000);
    chk("pin1_carry", 64'(pe.carry), 64'd1);
    chk("pin1_mant",  64'(pe.mant),  64'd0);
    chk("pin1_zero",  64'(pe.zero),  64'd0);
    pe = model(0, 0, 1, 3'd2, 48'hC00000_000000, 48'hC00000_000000);
    chk("pin2_zero",  64'(pe.zero),  64'd1);
    chk("pin2_sign",  64'(pe.sign),  64'd1);
    chk("pin2_lzc",   64'(pe.lzc),   64'd24);
    pe = model(0, 1, 0, 3'd0, 48'h800000_000000, 48'h000001_000000);
    chk("pin3_mant",  64'(pe.mant),  64'h7FFFFF);
    chk("pin3_lzc",   64'(pe.lzc),   64'd1);
    pe = model(0, 0, 0, 3'd0, 48'h800000_000000, 48'h000000_000001);
    chk("pin4_grs",   64'({pe.guard, pe.rnd, pe.sticky}), 64'b001);
    pe = model(0, 0, 0, 3'd0, 48'h800000_000000, 48'h000000_C00000);
    chk("pin4b_grs",  64'({pe.guard, pe.rnd, pe.sticky}), 64'b110);

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_valid", 64'(bif.out_valid), 64'd0);
    chk("rst_in_ready",  64'(bif.in_ready),  64'd1);
    chk("rst_data", 64'({bif.mant_sum, bif.carry, bif.guard, bif.round_b, bif.sticky,
                         bif.lzc, bif.sign_res, bif.zero_res}), 64'd0);

    // Directed vectors, full throughput
    send(0, 0, 0, 3'd0, 48'h800000_000000, 48'h800000_000000);
    send(0, 0, 1, 3'd0, 48'hC00000_000000, 48'hC00000_000000);
    send(0, 0, 1, 3'd2, 48'hC00000_000000, 48'hC00000_000000);
    send(0, 1, 0, 3'd0, 48'h800000_000000, 48'h000001_000000);
    send(0, 0, 0, 3'd0, 48'h800000_000000, 48'h000000_000001);
    send(0, 0, 0, 3'd0, 48'h800000_000000, 48'h000000_C00000);
    send(0, 0, 1, 3'd0, 48'h100000_000000, 48'h300000_000000);
    send(1, 1, 0, 3'd0, 48'h0,             48'h0);
    send(1, 0, 0, 3'd2, 48'h123456_789ABC, 48'h123456_789ABC);
    send(1, 0, 0, 3'd3, 48'h123456_789ABC, 48'h123456_789ABC);
    send(1, 1, 0, 3'd4, 48'hFFFFFF_FFFFFF, 48'hFFFFFF_FFFFFF);
    send(1, 0, 1, 3'd1, 48'h000000_000003, 48'h000000_000001);
    drain();

    // Stall: stream four ops, hold out_ready low three cycles after first result
    fork
      begin
        send(0, 0, 0, 3'd0, 48'h400000_000001, 48'h200000_000000);
        send(0, 1, 0, 3'd0, 48'h400000_000000, 48'h500000_800000);
        send(1, 1, 1, 3'd2, 48'h010000_000000, 48'h000100_400000);
        send(0, 0, 0, 3'd0, 48'h000000_FFFFFF, 48'h000000_000001);
      end
      begin
        int n = 0;
        @(posedge clk); #1;
        while (!bif.out_valid && n < 20) begin @(posedge clk); #1; n++; end
        if (!bif.out_valid) chk("stall_wait_timeout", 64'd0, 64'd1);
        bif.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 bif.out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two ops in flight: nothing may emerge afterwards
    send(0, 0, 0, 3'd0, 48'h111111_111111, 48'h222222_222222);
    send(0, 0, 0, 3'd0, 48'h333333_333333, 48'h444444_444444);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("post_rst_out_valid", 64'(bif.out_valid), 64'd0);
    chk("post_rst_in_ready",  64'(bif.in_ready),  64'd1);
    repeat (10) @(posedge clk);
    #1;

    // Traffic still flows after the mid-stream reset
    send(0, 1, 0, 3'd0, 48'hABCDEF_000000, 48'h000000_000010);
    drain();
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
